// File: rtl/mdu_if.sv
// Request/response bundle between the EXE stage and the multiply/divide unit.
interface mdu_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        kill;
    logic        advance;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;

    modport master (
        output req, op, src1, src2, kill, advance,
        input  busy, done, rd_data
    );

    modport slave (
        input  req, op, src1, src2, kill, advance,
        output busy, done, rd_data
    );
endinterface

// File: rtl/mdu.sv
// RV32M multiply/divide unit for the EXE stage.
// Multiplies take a single compute cycle; divides run a 32-step restoring
// loop, except divide-by-zero and signed overflow, which finish immediately.
module mdu (
    input  logic clk,
    input  logic rstn,
    mdu_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_r;
    logic [2:0]  op_r;
    logic [31:0] a_r;      // MUL: rs1; DIV: dividend shifting out, quotient shifting in
    logic [31:0] b_r;      // MUL: rs2; DIV: divisor magnitude
    logic [31:0] rem_r;    // DIV: partial remainder
    logic [4:0]  cnt_r;    // DIV: step index
    logic        neg_q_r;  // quotient must be negated at the end
    logic        neg_r_r;  // remainder must be negated at the end
    logic [31:0] res_r;

    // Magnitude of a value when it is treated as signed.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    // Two's complement negate on request.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    logic               signed_div_s;
    logic               div_zero_s;
    logic               div_ovf_s;
    logic [31:0]        special_res_s;
    logic signed [32:0] mul_a_s;
    logic signed [32:0] mul_b_s;
    logic signed [65:0] prod_s;
    logic [31:0]        mul_res_s;
    logic [32:0]        shift_s;
    logic [33:0]        diff_s;
    logic [31:0]        rem_next_s;
    logic [31:0]        quo_next_s;
    logic [31:0]        div_res_s;

    // Divide special cases, decided from the live operands while idle.
    always_comb begin
        signed_div_s = ~bus.op[0];
        div_zero_s   = (bus.src2 == 32'd0);
        div_ovf_s    = signed_div_s && (bus.src1 == 32'h8000_0000) && (bus.src2 == 32'hFFFF_FFFF);
        if (div_zero_s) begin
            special_res_s = bus.op[1] ? bus.src1 : 32'hFFFF_FFFF;
        end else begin
            special_res_s = bus.op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // 33x33 signed multiply; the extra bit selects signed or unsigned operands.
    always_comb begin
        mul_a_s = {((op_r[1:0] == 2'b01) || (op_r[1:0] == 2'b10)) & a_r[31], a_r};
        mul_b_s = {(op_r[1:0] == 2'b01) & b_r[31], b_r};
        prod_s  = 66'(mul_a_s) * 66'(mul_b_s);
        if (op_r[1:0] == 2'b00) begin
            mul_res_s = prod_s[31:0];
        end else begin
            mul_res_s = prod_s[63:32];
        end
    end

    // One restoring division step plus the sign fix-up used on the last step.
    always_comb begin
        shift_s    = {rem_r, a_r[31]};
        diff_s     = {1'b0, shift_s} - {2'b00, b_r};
        if (diff_s[33]) begin
            rem_next_s = shift_s[31:0];
        end else begin
            rem_next_s = diff_s[31:0];
        end
        quo_next_s = {a_r[30:0], ~diff_s[33]};
        if (op_r[1]) begin
            div_res_s = cond_neg(rem_next_s, neg_r_r);
        end else begin
            div_res_s = cond_neg(quo_next_s, neg_q_r);
        end
    end

    // Control FSM and datapath registers; kill outranks every other input.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= S_IDLE;
            op_r    <= 3'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            rem_r   <= 32'd0;
            cnt_r   <= 5'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            res_r   <= 32'd0;
        end else if (bus.kill) begin
            state_r <= S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.req) begin
                        op_r <= bus.op;
                        if (!bus.op[2]) begin
                            a_r     <= bus.src1;
                            b_r     <= bus.src2;
                            state_r <= S_MUL;
                        end else if (div_zero_s || div_ovf_s) begin
                            res_r   <= special_res_s;
                            state_r <= S_DONE;
                        end else begin
                            a_r     <= mag32(bus.src1, signed_div_s);
                            b_r     <= mag32(bus.src2, signed_div_s);
                            rem_r   <= 32'd0;
                            cnt_r   <= 5'd0;
                            neg_q_r <= signed_div_s & (bus.src1[31] ^ bus.src2[31]);
                            neg_r_r <= signed_div_s & bus.src1[31];
                            state_r <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (!bus.req) begin
                        state_r <= S_IDLE;
                    end else begin
                        res_r   <= mul_res_s;
                        state_r <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (!bus.req) begin
                        state_r <= S_IDLE;
                    end else begin
                        a_r   <= quo_next_s;
                        rem_r <= rem_next_s;
                        cnt_r <= cnt_r + 5'd1;
                        if (cnt_r == 5'd31) begin
                            res_r   <= div_res_s;
                            state_r <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.advance) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = bus.req & ~bus.kill & (state_r != S_DONE);
    assign bus.done    = (state_r == S_DONE);
    assign bus.rd_data = res_r;
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn  input  1  reset, asynchronous assertion, active-low.
REQ-003 SHALL have port req  input  1  EXE holds a valid RV32M instruction; stays stable while busy=1.
REQ-004 SHALL have port op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL have port src1  input  32  rs1 operand, sampled when an operation starts.
REQ-006 SHALL have port src2  input  32  rs2 operand, sampled when an operation starts.
REQ-007 SHALL have port kill  input  1  EXE flushed (trap/irq/redirect); aborts the current operation.
REQ-008 SHALL have port advance  input  1  EXE instruction leaves the stage this cycle.
REQ-009 SHALL have port busy  output  1  result not yet available; drives the hazard unit's exe_hazard.
REQ-010 SHALL have port done  output  1  rd_data valid this cycle.
REQ-011 SHALL have port rd_data  output  32  operation result.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 IDLE: req=1, kill=0, op[2]=0 -> latch operands, go to MUL.
REQ-014 IDLE: req=1, kill=0, op[2]=1, src2=0 -> go directly to DONE; quotient 0xFFFFFFFF, remainder src1 (signed and unsigned).
REQ-015 IDLE: req=1, kill=0, op=DIV/REM, src1=0x80000000, src2=0xFFFFFFFF -> go directly to DONE; quotient 0x80000000, remainder 0.
REQ-016 IDLE: other divide -> latch magnitudes (absolute values for DIV/REM, raw for DIVU/REMU) and result signs, clear 5-bit counter, go to DIV.
REQ-017 MUL: form 64-bit product (signed x signed MULH, signed x unsigned MULHSU, unsigned x unsigned MULHU/MUL); register low 32 bits for MUL, high 32 bits otherwise; go to DONE.
REQ-018 DIV: one restoring radix-2 step per cycle (shift remainder/quotient left 1, subtract divisor if no borrow); after counter reaches 31 apply sign fix-up and go to DONE.
REQ-019 Sign fix-up: quotient negated when dividend and divisor signs differ (DIV only); remainder takes dividend sign (REM only).
REQ-020 DONE: done=1, rd_data holds result; advance=1 -> IDLE; advance=0 -> remain in DONE, result unchanged, no restart.
REQ-021 busy SHALL equal req & ~kill & (state != DONE), combinational.
REQ-022 done SHALL equal (state == DONE); rd_data SHALL be the result register, unchanged outside DONE transitions.
REQ-023 Latency from req (cycle 0, IDLE): MUL* done in cycle 2; divide special case done in cycle 1; normal divide done in cycle 33.
REQ-024 kill=1 in any state SHALL force IDLE next cycle with no done pulse; kill has priority over advance and req.
REQ-025 req=0 in MUL or DIV (without kill) SHALL also abort to IDLE.
REQ-026 A new instruction SHALL start only from IDLE; back-to-back ops add one IDLE cycle.
REQ-027 All arithmetic SHALL be modulo 2^32 on results; no exceptions raised.

Reset
REQ-028 rstn=0 SHALL asynchronously force state IDLE, counter 0, result register 0, latched operands 0.
REQ-029 During and immediately after reset: busy=0 (while req=0), done=0, rd_data=0x00000000.
REQ-030 Reset mid-operation SHALL discard the operation; no done pulse follows.

Verification
REQ-031 MULH src1=0x80000000, src2=0x80000000 -> busy=1 cycles 0-1, done=1 cycle 2, rd_data=0x40000000.
REQ-032 DIV src1=0xFFFFFFF9 (-7), src2=2 -> busy=1 cycles 0-32, done cycle 33, rd_data=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-033 DIVU src1=100, src2=0 -> done cycle 1, rd_data=0xFFFFFFFF; REMU -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1.
REQ-034 DIVU 1000/7 with kill=1 at cycle 10 -> IDLE cycle 11, busy=0, no done; new MUL 3x5 then -> rd_data=15.
REQ-035 MUL 6x7 with advance=0 for 5 cycles after done -> done and rd_data=42 held each cycle, busy=0, no restart.
REQ-036 rstn pulse low at cycle 20 of DIVU -> state IDLE, rd_data=0, done stays 0 after release.
